// File: rtl/kitchen_timer_pkg.sv
// kitchen_timer_pkg: shared state encoding, 7-segment and anode tables for the kitchen timer.
package kitchen_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ALARM} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [15:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  // Active-low {g,f,e,d,c,b,a} patterns, digit 9 in the top slice down to digit 0
  localparam logic [69:0] SEG_TABLE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                       7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK[6:0] : SEG_TABLE[int'(d) * 7 +: 7];
  endfunction
endpackage

// File: rtl/mmss_bcd_counter.sv
// mmss_bcd_counter: MM:SS BCD time register with field increments and a one-second decrement.
module mmss_bcd_counter #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       dec,
  output logic [3:0] m_t,
  output logic [3:0] m_o,
  output logic [3:0] s_t,
  output logic [3:0] s_o,
  output logic       is_zero
);
  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);
  assign is_zero = {m_t, m_o, s_t, s_o} == 16'h0000;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {m_t, m_o, s_t, s_o} <= '0;
    else if (inc_min) begin
      if (m_t == MAX_T && m_o == MAX_O) {m_t, m_o} <= '0;
      else if (m_o == 4'd9) begin
        m_t <= m_t + 4'd1;
        m_o <= '0;
      end else m_o <= m_o + 4'd1;
    end else if (inc_sec) begin
      s_o <= s_o == 4'd9 ? 4'd0 : s_o + 4'd1;
      if (s_o == 4'd9) s_t <= s_t == 4'd5 ? 4'd0 : s_t + 4'd1;
    end else if (dec) begin
      // Borrow ripples through each field; never applied at 00:00
      s_o <= s_o == 4'd0 ? 4'd9 : s_o - 4'd1;
      if (s_o == 4'd0) begin
        s_t <= s_t == 4'd0 ? 4'd5 : s_t - 4'd1;
        if (s_t == 4'd0) begin
          m_o <= m_o == 4'd0 ? 4'd9 : m_o - 4'd1;
          if (m_o == 4'd0) m_t <= m_t - 4'd1;
        end
      end
    end
endmodule

// File: rtl/kitchen_timer_core.sv
// kitchen_timer_core: countdown kitchen timer FSM with prescaler, alarm timeout and multiplexed display.
module kitchen_timer_core
  import kitchen_timer_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000,
  parameter int ALARM_SECS = 10,
  parameter int MAX_MIN    = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       increase,
  input  logic       min,
  input  logic       sec,
  output logic [7:0] seg,
  output logic [3:0] AN,
  output logic       running,
  output logic       alarm
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n, presc_inc;
  logic [AW-1:0] asec, asec_n;
  logic [SW-1:0] scan;
  logic [1:0] idx;
  logic [3:0] m_t, m_o, s_t, s_o, dig;
  logic inc_m, inc_s, dec, tick, is_zero, is_one, scan_wrap;
  mmss_bcd_counter #(.MAX_MIN(MAX_MIN)) u_bcd (
    .clk(clk), .reset(reset), .inc_min(inc_m), .inc_sec(inc_s), .dec(dec),
    .m_t(m_t), .m_o(m_o), .s_t(s_t), .s_o(s_o), .is_zero(is_zero)
  );
  assign tick = presc == PW'(TICK_DIV - 1);
  assign presc_inc = tick ? '0 : presc + 1'b1;
  assign is_one = {m_t, m_o, s_t, s_o} == 16'h0001;
  always_comb begin
    state_n = state;
    presc_n = presc;
    asec_n = asec;
    inc_m = 1'b0;
    inc_s = 1'b0;
    dec = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          if (!is_zero) begin
            state_n = RUN;
            presc_n = '0;
          end
        end else if (increase) begin
          inc_m = min;
          inc_s = sec & ~min;
        end
      RUN:
        if (pause) state_n = PAUSED;
        else begin
          presc_n = presc_inc;
          dec = tick;
          if (tick && is_one) begin
            state_n = ALARM;
            asec_n = '0;
          end
        end
      PAUSED: if (start | pause) state_n = RUN;
      ALARM:
        if (start | pause) begin
          state_n = IDLE;
          presc_n = '0;
        end else begin
          // Prescaler is reused to time the alarm seconds
          presc_n = presc_inc;
          if (tick) begin
            asec_n = asec == AW'(ALARM_SECS - 1) ? '0 : asec + 1'b1;
            if (asec == AW'(ALARM_SECS - 1)) state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      presc <= '0;
      asec <= '0;
      running <= 1'b0;
      alarm <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      asec <= asec_n;
      running <= state_n == RUN;
      alarm <= state_n == ALARM;
    end
  assign scan_wrap = scan == SW'(SCAN_DIV - 1);
  assign dig = idx == 2'd0 ? s_o : idx == 2'd1 ? s_t : idx == 2'd2 ? m_o : m_t;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scan <= '0;
      idx <= '0;
      seg <= 8'hC0;
      AN <= AN_TABLE[3:0];
    end else begin
      scan <= scan_wrap ? '0 : scan + 1'b1;
      if (scan_wrap) idx <= idx + 2'd1;
      seg <= {idx != 2'd2, seg7(dig)};
      AN <= (state == ALARM && asec[0]) ? AN_OFF : AN_TABLE[{idx, 2'b00} +: 4];
    end
endmodule

// File: doc/kitchen_timer_core.md
Name: kitchen_timer_core

Overview:
Parametrised countdown kitchen timer: MM:SS BCD time set by button pulses, counts down once per second, raises an alarm at 00:00 and drives a 4-digit multiplexed 7-segment display. Successor to the first-generation timer top: adds pause/resume, alarm timeout and generic tick/scan dividers. Sits behind the debouncer; all button inputs are already debounced single-cycle pulses or stable levels.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown second (>=2)
SCAN_DIV, 50000, clk cycles each display digit is enabled (>=1)
ALARM_SECS, 10, seconds alarm stays asserted before auto-return to IDLE (>=1)
MAX_MIN, 99, highest settable minute value; increment wraps MAX_MIN->00 (1..99)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: start/resume
pause  in  1  single-cycle pulse: pause/resume/acknowledge alarm
increase  in  1  single-cycle pulse: increment selected field
min  in  1  level: select minutes field
sec  in  1  level: select seconds field
seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
AN  out  4  active-low digit enables, AN[0]=seconds ones
running  out  1  high in RUN
alarm  out  1  high in ALARM

Behaviour:
- Reset (reset=0, async): state IDLE, time 00:00, prescaler 0, scan index 0, AN=4'b1110, seg=8'hC0, running=0, alarm=0.
- States IDLE, RUN, PAUSED, ALARM; registered, one transition per clk.
- IDLE: increase with min=1 -> minutes+1 (MAX_MIN->00, seconds untouched); increase with sec=1,min=0 -> seconds+1 (59->00, no carry); neither -> no change. start with time!=00:00 -> RUN, prescaler cleared; start at 00:00 ignored. pause ignored. start and increase same cycle: start evaluated on pre-increment time, increment dropped.
- RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 decrement time (SS 00 -> 59 with MM-1). First decrement exactly TICK_DIV cycles after the start pulse cycle. Decrement reaching 00:00 -> ALARM same edge. pause -> PAUSED (pause wins over start and over a coincident tick: no decrement). increase ignored.
- PAUSED: prescaler and time frozen. start or pause -> RUN, prescaler resumes from held value. increase ignored.
- ALARM: time held 00:00; alarm=1; prescaler reused to count ALARM_SECS seconds, then -> IDLE. start or pause -> IDLE immediately.
- running=(state==RUN), alarm=(state==ALARM), both registered outputs.
- Display: scan counter 0..SCAN_DIV-1, digit index 0..3 advances on wrap; AN one-hot-low 1110,1101,1011,0111. Digit 0=S ones, 1=S tens, 2=M ones, 3=M tens. seg[6:0] standard active-low decode of 0-9; seg[7] (dp) low only on digit 2 (colon). In ALARM, all AN forced 1111 during odd alarm seconds (blink). Display update registered: seg/AN change one cycle after index change.
- BCD fields always legal (digits 0-9, seconds tens 0-5); no illegal encodings reachable.

Decomposition:
- Package kitchen_timer_pkg: state encoding constants, 7-seg pattern table for 0-9, anode pattern constants, SEG_BLANK.
- Sub-module mmss_bcd_counter: holds MM:SS BCD, inputs inc_min, inc_sec, dec, MAX_MIN parameter; outputs four digits and is_zero. Remaining FSM, prescaler and scan mux in kitchen_timer_core.

Test Plan:
- TICK_DIV=4, SCAN_DIV=2; reset, 3 sec-increase pulses, start -> running=1; decrements at +4,+8,+12 cycles; after 00:03->00:00 alarm=1, running=0.
- Set 01:00, start, after one tick -> time 00:59; minute borrow correct; seg on digit 1 = 8'h92 ('5').
- Set 00:05, start, pause after 6 cycles -> time frozen 00:04 for 20 cycles; pause again -> next decrement exactly 2 cycles later.
- 100 min-increase pulses from 00:00 (MAX_MIN=99) -> minutes 00; 60 sec-increases -> seconds 00, minutes unchanged; start at 00:00 -> stays IDLE.
- ALARM_SECS=2: alarm stays 8 cycles then IDLE; separately pause pulse in ALARM -> IDLE next cycle; AN=1111 during odd alarm second.
- Assert reset mid-RUN at arbitrary phase -> same cycle outputs AN=1110, seg=8'hC0, running=0, alarm=0; release -> IDLE 00:00.
